// File: rtl/ntsc_rgb2yuv_pipe.sv
// RGB to Y/U/V converter for NTSC video, 3-stage pipeline, BT.601 / BT.709 selectable per frame.
// Every register advances only on clock-enabled cycles; chroma is saturated two's complement.
module ntsc_rgb2yuv_pipe #(
   parameter int unsigned C_DW = 8
) (
   input  logic            CK_i,
   input  logic            XAR_i,
   input  logic            CK_EE_i,
   input  logic            DE_i,
   input  logic            SOF_i,
   input  logic            MODE_i,
   input  logic [C_DW-1:0] DATs_R_i,
   input  logic [C_DW-1:0] DATs_G_i,
   input  logic [C_DW-1:0] DATs_B_i,
   output logic [C_DW-1:0] YYs_o,
   output logic [C_DW-1:0] UUs_o,
   output logic [C_DW-1:0] VVs_o,
   output logic            DE_o,
   output logic            MODE_o
);

   localparam int unsigned PW = C_DW + 8;
   localparam int unsigned SW = C_DW + 10;
   localparam int          SMAX_I = (1 << (C_DW - 1)) - 1;
   localparam logic signed [SW-1:0] SMAX = SW'(SMAX_I);
   localparam logic signed [SW-1:0] SMIN = SW'(-SMAX_I - 1);

   logic              act_mode;

   // stage 1
   logic [PW-1:0]     p_r, p_g, p_b;
   logic [C_DW-1:0]   r1, b1;
   logic              de1, m1;

   // stage 2
   logic [C_DW-1:0]   y2, r2, b2;
   logic              de2, m2;

   logic              mode_cur_c;
   logic [7:0]        kyr_c, kyg_c, kyb_c, ku_c, kv_c;
   logic [PW:0]       ysum_c;
   logic [C_DW-1:0]   y_c;
   logic signed [SW-1:0] du_c, dv_c, pu_c, pv_c, us_c, vs_c;
   logic [C_DW-1:0]   u_sat_c, v_sat_c;

   function automatic logic [C_DW-1:0] sat(input logic signed [SW-1:0] x);
      if (x > SMAX)      return C_DW'(SMAX);
      else if (x < SMIN) return C_DW'(SMIN);
      else               return C_DW'(x);
   endfunction

   // The SOF cycle's pixel already uses the mode being loaded.
   always_comb begin
      mode_cur_c = SOF_i ? MODE_i : act_mode;
      kyr_c = mode_cur_c ? 8'd54  : 8'd77;
      kyg_c = mode_cur_c ? 8'd183 : 8'd150;
      kyb_c = mode_cur_c ? 8'd19  : 8'd29;
   end

   always_comb begin
      ysum_c = (PW+1)'(p_r) + (PW+1)'(p_g) + (PW+1)'(p_b) + (PW+1)'(128);
      y_c    = C_DW'(ysum_c >> 8);
   end

   // Chroma uses the mode carried alongside the pixel, never the live register.
   always_comb begin
      ku_c    = m2 ? 8'd138 : 8'd126;
      kv_c    = m2 ? 8'd163 : 8'd224;
      du_c    = SW'(b2) - SW'(y2);
      dv_c    = SW'(r2) - SW'(y2);
      pu_c    = du_c * $signed(SW'(ku_c)) + $signed(SW'(128));
      pv_c    = dv_c * $signed(SW'(kv_c)) + $signed(SW'(128));
      us_c    = pu_c >>> 8;
      vs_c    = pv_c >>> 8;
      u_sat_c = sat(us_c);
      v_sat_c = sat(vs_c);
   end

   always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
         act_mode <= 1'b0;
         p_r      <= '0;
         p_g      <= '0;
         p_b      <= '0;
         r1       <= '0;
         b1       <= '0;
         de1      <= 1'b0;
         m1       <= 1'b0;
         y2       <= '0;
         r2       <= '0;
         b2       <= '0;
         de2      <= 1'b0;
         m2       <= 1'b0;
         YYs_o    <= '0;
         UUs_o    <= '0;
         VVs_o    <= '0;
         DE_o     <= 1'b0;
         MODE_o   <= 1'b0;
      end else if (CK_EE_i) begin
         if (SOF_i) act_mode <= MODE_i;

         p_r <= PW'(DATs_R_i) * PW'(kyr_c);
         p_g <= PW'(DATs_G_i) * PW'(kyg_c);
         p_b <= PW'(DATs_B_i) * PW'(kyb_c);
         r1  <= DATs_R_i;
         b1  <= DATs_B_i;
         de1 <= DE_i;
         m1  <= mode_cur_c;

         y2  <= y_c;
         r2  <= r1;
         b2  <= b1;
         de2 <= de1;
         m2  <= m1;

         YYs_o  <= de2 ? y2      : '0;
         UUs_o  <= de2 ? u_sat_c : '0;
         VVs_o  <= de2 ? v_sat_c : '0;
         DE_o   <= de2;
         MODE_o <= m2;
      end
   end

endmodule

// File: tb/tb_ntsc_rgb2yuv_pipe.sv
// Directed bench for ntsc_rgb2yuv_pipe: table of hand-computed pixels plus
// clock-enable, mode-latching and mid-stream reset sequences.
module tb_ntsc_rgb2yuv_pipe;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, de = 1'b0, sof = 1'b0, mode = 1'b0;
   logic [DW-1:0] r = '0, g = '0, b = '0;
   logic [DW-1:0] y_o, u_o, v_o;
   logic          de_o, mode_o;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       sof, mode, de;
      logic [7:0] r, g, b;
      logic [7:0] y, u, v;
      logic       de_o, mode_o;
   } vec_t;

   vec_t       vt [12];
   logic [7:0] hist [64];
   int         en_cnt;

   ntsc_rgb2yuv_pipe #(.C_DW(DW)) dut (
      .CK_i     (clk),
      .XAR_i    (rst_n),
      .CK_EE_i  (en),
      .DE_i     (de),
      .SOF_i    (sof),
      .MODE_i   (mode),
      .DATs_R_i (r),
      .DATs_G_i (g),
      .DATs_B_i (b),
      .YYs_o    (y_o),
      .UUs_o    (u_o),
      .VVs_o    (v_o),
      .DE_o     (de_o),
      .MODE_o   (mode_o)
   );

   always #5 clk = ~clk;

   function automatic logic [25:0] mk(input logic d, input logic m,
                                      input logic [7:0] yy, input logic [7:0] uu,
                                      input logic [7:0] vv);
      return {d, m, yy, uu, vv};
   endfunction

   function automatic logic [25:0] outv();
      return {de_o, mode_o, y_o, u_o, v_o};
   endfunction

   task automatic chk(input string nm, input logic [25:0] got, input logic [25:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got de=%b mode=%b y=%h u=%h v=%h, expected de=%b mode=%b y=%h u=%h v=%h",
                    nm, got[25], got[24], got[23:16], got[15:8], got[7:0],
                    exp[25], exp[24], exp[23:16], exp[15:8], exp[7:0]);
   endtask

   task automatic drive(input logic e, input logic d, input logic s, input logic m,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
      en = e; de = d; sof = s; mode = m; r = rr; g = gg; b = bb;
   endtask

   initial begin
      //            sof   mode  de    R      G      B      Y      U      V      de_o  mode_o
      vt[0]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h4D, 8'hDA, 8'h7F, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h1D, 8'h6F, 8'hE7, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h36, 8'hE3, 8'h7F, 1'b1, 1'b1};
      vt[4]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h36, 8'hE3, 8'h7F, 1'b1, 1'b1};
      vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hB6, 8'h9E, 8'h8C, 1'b1, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 8'h80, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h95, 8'hB7, 8'h80, 1'b1, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h13, 8'h7F, 8'hF4, 1'b1, 1'b1};
      vt[10] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

      // Reset held with active inputs and a running clock
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      repeat (2) @(negedge clk);
      chk("reset_hold", outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back table pixels; output i appears three enabled edges after input i
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (i >= 3)
            chk($sformatf("vec%0d", i - 3), outv(),
                mk(vt[i-3].de_o, vt[i-3].mode_o, vt[i-3].y, vt[i-3].u, vt[i-3].v));
         if (i < 12)
            drive(1'b1, vt[i].de, vt[i].sof, vt[i].mode, vt[i].r, vt[i].g, vt[i].b);
         else
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      end

      // Gray ramp (Y = level, U = V = 0) with irregular clock enable
      en_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (en_cnt >= 3)
            chk($sformatf("ce_ramp%0d", c), outv(),
                mk(1'b1, 1'b0, hist[en_cnt-3], 8'h00, 8'h00));
         if ((c % 3) != 1) begin
            hist[en_cnt] = 8'(16 + 7 * en_cnt);
            drive(1'b1, 1'b1, 1'b0, 1'b0, hist[en_cnt], hist[en_cnt], hist[en_cnt]);
            en_cnt++;
         end else begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE, 8'h11, 8'hEE);
         end
      end

      // Fill pipeline with BT.709 white, then reset mid-stream
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset", outv(), mk(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00));
      #2 rst_n = 1'b0;
      en = 1'b0;
      #1 chk("async_reset", outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
      @(negedge clk);
      chk("reset_no_ce", outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
      // MODE_i=1 without SOF must not change the reset mode (BT.601)
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         if (k < 2) chk($sformatf("post_rst_lat%0d", k), outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));
         else       chk("post_rst_first", outv(), mk(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00));
      end
      @(negedge clk);
      chk("post_rst_drain", outv(), mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h00));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ntsc_rgb2yuv_pipe.md
NTSC_RGB2YUV_PIPE -- requirements
Module: ntsc_rgb2yuv_pipe

Interface
REQ-001 SHALL have parameter C_DW, default 8, meaning component width for R/G/B in and Y/U/V out, legal range 8..12.
REQ-002 SHALL have port CK_i  input  1  system clock (4fsc); all state changes on its rising edge.
REQ-003 SHALL have port XAR_i  input  1  reset, asynchronous, active-low, tri1 default.
REQ-004 SHALL have port CK_EE_i  input  1  clock enable, tri1 default; when 0, every register holds.
REQ-005 SHALL have port DE_i  input  1  input pixel valid.
REQ-006 SHALL have port SOF_i  input  1  start-of-frame, qualified by CK_EE_i only.
REQ-007 SHALL have port MODE_i  input  1  matrix select, 0=BT.601, 1=BT.709.
REQ-008 SHALL have ports DATs_R_i, DATs_G_i, DATs_B_i  input  C_DW each  unsigned RGB, tri0 default.
REQ-009 SHALL have port YYs_o  output  C_DW  unsigned luma.
REQ-010 SHALL have ports UUs_o, VVs_o  output  C_DW each  2's-complement chroma.
REQ-011 SHALL have port DE_o  output  1  output pixel valid.
REQ-012 SHALL have port MODE_o  output  1  matrix used for the current output pixel.

Function
REQ-013 SHALL advance the pipeline only on cycles with CK_EE_i=1; "stage" below means one enabled cycle.
REQ-014 SHALL hold an active-mode register, loaded from MODE_i on an enabled cycle with SOF_i=1, otherwise unchanged; MODE_i changes without SOF_i have no effect.
REQ-015 SHALL use the just-loaded MODE_i value for the pixel presented in the SOF_i cycle.
REQ-016 SHALL carry the active mode with each pixel through all stages so a single pixel never mixes matrices.
REQ-017 SHALL use coefficients /256: BT.601 Y=(77,150,29), K_U=126, K_V=224; BT.709 Y=(54,183,19), K_U=138, K_V=163.
REQ-018 Stage 1 SHALL register the three Y products and delayed copies of R, B, DE, mode.
REQ-019 Stage 2 SHALL register Y=(sum+128)>>8, width C_DW (coefficient sums are 256, so no overflow).
REQ-020 Stage 3 SHALL compute U=((B-Y)*K_U+128)>>>8 and V=((R-Y)*K_V+128)>>>8 in signed C_DW+10 bits, arithmetic shift (floor).
REQ-021 Stage 3 SHALL saturate U,V to [-2^(C_DW-1), 2^(C_DW-1)-1] (0x80..0x7F for C_DW=8).
REQ-022 Stage 3 SHALL register Y aligned with U,V; latency DE_i->DE_o is exactly 3 enabled cycles.
REQ-023 SHALL drive YYs_o=0, UUs_o=0, VVs_o=0 on output cycles with DE_o=0.
REQ-024 SHALL accept a new pixel every enabled cycle (throughput 1), with no bubbles or back-pressure.
REQ-025 SHALL treat SOF_i with DE_i=0 as a valid mode load.

Reset
REQ-026 SHALL, while XAR_i=0, force YYs_o, UUs_o, VVs_o, DE_o, MODE_o, the active mode and all pipeline registers to 0 (mode=BT.601), regardless of CK_EE_i.
REQ-027 SHALL, after reset mid-stream, emit DE_o=0 until 3 enabled cycles after the first post-reset DE_i=1.

Verification (C_DW=8)
REQ-028 Reset, SOF+MODE=0, R=G=B=0xFF, DE=1 -> 3 enabled cycles later Y=0xFF, U=0x00, V=0x00, DE_o=1, MODE_o=0.
REQ-029 BT.601 red (FF,00,00) -> Y=0x4D, U=0xDA, V=0x7F (saturated); blue (00,00,FF) -> Y=0x1D, U=0x6F, V=0xE7.
REQ-030 SOF+MODE=1, red -> Y=0x36, U=0xE3, V=0x7F (saturated), MODE_o=1; then MODE_i=0 mid-frame without SOF -> outputs unchanged, MODE_o stays 1.
REQ-031 CK_EE_i toggling 1/0 with a continuous pixel ramp -> outputs change only on enabled cycles, latency exactly 3 enabled cycles, no pixel lost or duplicated.
REQ-032 XAR_i pulsed low with pipeline full -> all outputs 0 immediately (asynchronously); DE_o remains 0 until 3 enabled cycles after the next DE_i=1; MODE_o=0.
REQ-033 DE_i=0 with non-zero RGB -> Y=U=V=0 and DE_o=0 at output.
